// File: rtl/mem_stage_ctrl.sv
// Memory stage controller for slot 0 of the dual-issue pipe.
// Issues word-aligned D-cache requests with byte enables, stalls the pipe
// while a request is outstanding, formats load data and drives MEM/WB.
module mem_stage_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     exmem_valid,
  input  logic                     exmem_ld_en,
  input  logic                     exmem_st_en,
  input  logic [2:0]               exmem_ld_type,
  input  logic [1:0]               exmem_st_type,
  input  logic [DATA_WIDTH-1:0]    exmem_addr,
  input  logic [DATA_WIDTH-1:0]    exmem_st_data,
  input  logic [DATA_WIDTH-1:0]    exmem_alu_result,
  input  logic [RF_ADDR_WIDTH-1:0] exmem_rd_addr,
  input  logic                     exmem_rd_wrt_en,
  input  logic                     flush,
  output logic                     dcache_req,
  output logic                     dcache_we,
  output logic [DATA_WIDTH-1:0]    dcache_addr,
  output logic [DATA_WIDTH-1:0]    dcache_wdata,
  output logic [3:0]               dcache_be,
  input  logic                     dcache_ack,
  input  logic [DATA_WIDTH-1:0]    dcache_rdata,
  output logic                     mem_stall,
  output logic                     MemWb_RdWrtEn_0,
  output logic [RF_ADDR_WIDTH-1:0] MemWb_RdAddr_0,
  output logic [DATA_WIDTH-1:0]    MemWb_Data_0,
  output logic [DATA_WIDTH-1:0]    Dcache_DataRd_0,
  output logic                     misalign_exc
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]               state_q, state_d;
  logic                     req_q, we_q, killed_q;
  logic [DATA_WIDTH-1:0]    addr_q, wdata_q;
  logic [3:0]               be_q;
  logic [1:0]               byteOff_q;
  logic [2:0]               ldType_q;
  logic [RF_ADDR_WIDTH-1:0] rd_q;
  logic                     wrtEn_q;

  logic                     wen_q, misalign_q;
  logic [RF_ADDR_WIDTH-1:0] wbRd_q;
  logic [DATA_WIDTH-1:0]    wbData_q, dataRd_q;

  logic                  isMem, isByte, isHalf, aligned, accept, stallRaw;
  logic [DATA_WIDTH-1:0] wdata_d, shifted, loadFmt;
  logic [3:0]            be_d;

  // Decode access size and alignment; undefined encodings fall back to word
  always_comb begin
    isMem = exmem_ld_en | exmem_st_en;
    if (exmem_ld_en) begin
      isByte = (exmem_ld_type[1:0] == 2'b00);
      isHalf = (exmem_ld_type[1:0] == 2'b01);
    end else begin
      isByte = (exmem_st_type == 2'b00);
      isHalf = (exmem_st_type == 2'b01);
    end
    aligned = isByte | (isHalf & ~exmem_addr[0]) |
              (~isByte & ~isHalf & (exmem_addr[1:0] == 2'b00));
    accept  = (state_q == IDLE) & exmem_valid & isMem & ~flush & aligned;
  end

  // Replicate store data across lanes and pick the byte enables
  always_comb begin
    wdata_d = '0;
    be_d    = 4'b1111;
    if (exmem_st_en) begin
      if (exmem_st_type == 2'b00) begin
        wdata_d = {4{exmem_st_data[7:0]}};
        be_d    = 4'b0001 << exmem_addr[1:0];
      end else if (exmem_st_type == 2'b01) begin
        wdata_d = {2{exmem_st_data[15:0]}};
        be_d    = exmem_addr[1] ? 4'b1100 : 4'b0011;
      end else begin
        wdata_d = exmem_st_data;
        be_d    = 4'b1111;
      end
    end
  end

  // Align the returned word to the byte offset and extend per load type
  always_comb begin
    shifted = dcache_rdata >> {byteOff_q, 3'b000};
    case (ldType_q)
      3'b000:  loadFmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadFmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  loadFmt = {24'h0, shifted[7:0]};
      3'b101:  loadFmt = {16'h0, shifted[15:0]};
      default: loadFmt = dcache_rdata;
    endcase
  end

  // Two-state FSM: leave IDLE on an accepted op, return on ack
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (accept) state_d = ACCESS;
    end else if (dcache_ack) begin
      state_d = IDLE;
    end
  end

  assign stallRaw  = accept | ((state_q == ACCESS) & ~dcache_ack);
  assign mem_stall = rst_n & stallRaw;

  // Request registers: captured on acceptance, held stable until ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      byteOff_q <= '0;
      ldType_q  <= '0;
      rd_q      <= '0;
      wrtEn_q   <= 1'b0;
      killed_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        killed_q <= 1'b0;
        if (accept) begin
          req_q     <= 1'b1;
          we_q      <= exmem_st_en;
          addr_q    <= {exmem_addr[DATA_WIDTH-1:2], 2'b00};
          wdata_q   <= wdata_d;
          be_q      <= be_d;
          byteOff_q <= exmem_addr[1:0];
          ldType_q  <= exmem_ld_type;
          rd_q      <= exmem_rd_addr;
          wrtEn_q   <= exmem_rd_wrt_en;
        end
      end else if (dcache_ack) begin
        req_q    <= 1'b0;
        killed_q <= 1'b0;
      end else if (flush) begin
        killed_q <= 1'b1;
      end
    end
  end

  // MEM/WB register: bubble while stalled, else capture the retiring op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q      <= 1'b0;
      wbRd_q     <= '0;
      wbData_q   <= '0;
      dataRd_q   <= '0;
      misalign_q <= 1'b0;
    end else if (stallRaw) begin
      wen_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      misalign_q <= 1'b0;
      wbRd_q     <= rd_q;
      if (we_q) begin
        wen_q <= 1'b0;
      end else begin
        wen_q    <= wrtEn_q & (rd_q != '0) & ~(killed_q | flush);
        wbData_q <= loadFmt;
        dataRd_q <= loadFmt;
      end
    end else begin
      wbRd_q     <= exmem_rd_addr;
      wen_q      <= exmem_valid & ~isMem & exmem_rd_wrt_en & ~flush &
                    (exmem_rd_addr != '0);
      misalign_q <= exmem_valid & isMem & ~aligned & ~flush;
      if (!isMem) wbData_q <= exmem_alu_result;
    end
  end

  assign dcache_req      = req_q;
  assign dcache_we       = we_q;
  assign dcache_addr     = addr_q;
  assign dcache_wdata    = wdata_q;
  assign dcache_be       = be_q;
  assign MemWb_RdWrtEn_0 = wen_q;
  assign MemWb_RdAddr_0  = wbRd_q;
  assign MemWb_Data_0    = wbData_q;
  assign Dcache_DataRd_0 = dataRd_q;
  assign misalign_exc    = misalign_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: table of single-cycle IDLE
// vectors followed by hand-written multi-cycle memory access sequences.
module tb_mem_stage_ctrl;

  logic        clk, rst_n;
  logic        exmem_valid, exmem_ld_en, exmem_st_en;
  logic [2:0]  exmem_ld_type;
  logic [1:0]  exmem_st_type;
  logic [31:0] exmem_addr, exmem_st_data, exmem_alu_result;
  logic [4:0]  exmem_rd_addr;
  logic        exmem_rd_wrt_en, flush;
  logic        dcache_req, dcache_we, dcache_ack;
  logic [31:0] dcache_addr, dcache_wdata, dcache_rdata;
  logic [3:0]  dcache_be;
  logic        mem_stall, MemWb_RdWrtEn_0, misalign_exc;
  logic [4:0]  MemWb_RdAddr_0;
  logic [31:0] MemWb_Data_0, Dcache_DataRd_0;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl #(.DATA_WIDTH(32), .RF_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .exmem_valid(exmem_valid), .exmem_ld_en(exmem_ld_en), .exmem_st_en(exmem_st_en),
    .exmem_ld_type(exmem_ld_type), .exmem_st_type(exmem_st_type),
    .exmem_addr(exmem_addr), .exmem_st_data(exmem_st_data),
    .exmem_alu_result(exmem_alu_result), .exmem_rd_addr(exmem_rd_addr),
    .exmem_rd_wrt_en(exmem_rd_wrt_en), .flush(flush),
    .dcache_req(dcache_req), .dcache_we(dcache_we), .dcache_addr(dcache_addr),
    .dcache_wdata(dcache_wdata), .dcache_be(dcache_be), .dcache_ack(dcache_ack),
    .dcache_rdata(dcache_rdata), .mem_stall(mem_stall),
    .MemWb_RdWrtEn_0(MemWb_RdWrtEn_0), .MemWb_RdAddr_0(MemWb_RdAddr_0),
    .MemWb_Data_0(MemWb_Data_0), .Dcache_DataRd_0(Dcache_DataRd_0),
    .misalign_exc(misalign_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid, ld, st, fl, wen;
    logic [2:0]  ldType;
    logic [1:0]  stType;
    logic [31:0] addr, alu;
    logic [4:0]  rd;
    logic        expWen, expMis, chkData;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    exmem_valid = 0; exmem_ld_en = 0; exmem_st_en = 0;
    exmem_ld_type = 3'b010; exmem_st_type = 2'b10;
    exmem_addr = 0; exmem_st_data = 0; exmem_alu_result = 0;
    exmem_rd_addr = 0; exmem_rd_wrt_en = 0; flush = 0;
    dcache_ack = 0; dcache_rdata = 0;
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] ldType,
                               input logic [1:0] stType, input logic [31:0] addr,
                               input logic [31:0] stData, input logic [4:0] rd);
    exmem_valid = 1; exmem_ld_en = ld; exmem_st_en = st;
    exmem_ld_type = ldType; exmem_st_type = stType;
    exmem_addr = addr; exmem_st_data = stData;
    exmem_rd_addr = rd; exmem_rd_wrt_en = ld; flush = 0;
  endtask

  // Drive a memory op at the current cycle, ack after ackAfter request
  // cycles, optionally flush in the first ACCESS cycle. Ends #1 after the
  // edge where MEM/WB captures the result.
  task automatic doMemOp(input logic ld, input logic st, input logic [2:0] ldType,
                         input logic [1:0] stType, input logic [31:0] addr,
                         input logic [31:0] stData, input logic [4:0] rd,
                         input int ackAfter, input logic [31:0] rdata, input logic flushIn,
                         input logic [31:0] expAddr, input logic [3:0] expBe,
                         input logic [31:0] expWdata, output int stallCnt);
    stallCnt = 0;
    applyStimulus(ld, st, ldType, stType, addr, stData, rd);
    #1;
    if (mem_stall) stallCnt++;
    for (int c = 1; c <= ackAfter; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        checkOutput("req_asserted", {31'b0, dcache_req}, 32'd1);
        checkOutput("req_addr", dcache_addr, expAddr);
        checkOutput("req_be", {28'b0, dcache_be}, {28'b0, expBe});
        checkOutput("req_we", {31'b0, dcache_we}, {31'b0, st});
        if (st) checkOutput("req_wdata", dcache_wdata, expWdata);
      end
      flush = flushIn && (c == 1);
      dcache_ack = (c == ackAfter);
      dcache_rdata = rdata;
      #1;
      if (mem_stall) stallCnt++;
    end
    @(posedge clk); #1;
    clearInputs();
    checkOutput("req_dropped", {31'b0, dcache_req}, 32'd0);
  endtask

  initial begin
    int stalls;
    vecs[0]  = '{1,0,0,0,1, 3'b010,2'b10, 32'h0,    32'h1234, 5'd5, 1,0,1, 32'h1234};
    vecs[1]  = '{1,0,0,0,1, 3'b010,2'b10, 32'h0,    32'h5555, 5'd0, 0,0,0, 32'h0};
    vecs[2]  = '{0,0,0,0,1, 3'b010,2'b10, 32'h0,    32'h6666, 5'd3, 0,0,0, 32'h0};
    vecs[3]  = '{1,0,0,1,1, 3'b010,2'b10, 32'h0,    32'h7777, 5'd4, 0,0,0, 32'h0};
    vecs[4]  = '{1,1,0,0,1, 3'b010,2'b10, 32'h3001, 32'h0,    5'd6, 0,1,0, 32'h0};
    vecs[5]  = '{1,0,0,0,1, 3'b010,2'b10, 32'h0,    32'hCAFE, 5'd8, 1,0,1, 32'hCAFE};
    vecs[6]  = '{1,1,0,1,1, 3'b001,2'b10, 32'h0101, 32'h0,    5'd2, 0,0,0, 32'h0};
    vecs[7]  = '{1,0,1,0,0, 3'b010,2'b10, 32'h0002, 32'h0,    5'd0, 0,1,0, 32'h0};
    vecs[8]  = '{1,1,0,0,1, 3'b101,2'b10, 32'h0103, 32'h0,    5'd9, 0,1,0, 32'h0};
    vecs[9]  = '{1,1,0,0,1, 3'b011,2'b10, 32'h0002, 32'h0,    5'd9, 0,1,0, 32'h0};
    vecs[10] = '{1,0,1,0,0, 3'b010,2'b01, 32'h0005, 32'h0,    5'd0, 0,1,0, 32'h0};

    clearInputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req", {31'b0, dcache_req}, 32'd0);
    checkOutput("rst_stall", {31'b0, mem_stall}, 32'd0);
    checkOutput("rst_wen", {31'b0, MemWb_RdWrtEn_0}, 32'd0);
    checkOutput("rst_data", MemWb_Data_0, 32'd0);
    checkOutput("rst_datard", Dcache_DataRd_0, 32'd0);
    checkOutput("rst_misalign", {31'b0, misalign_exc}, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // Table-driven single-cycle vectors in IDLE
    for (int i = 0; i < 11; i++) begin
      exmem_valid = vecs[i].valid; exmem_ld_en = vecs[i].ld; exmem_st_en = vecs[i].st;
      exmem_ld_type = vecs[i].ldType; exmem_st_type = vecs[i].stType;
      exmem_addr = vecs[i].addr; exmem_alu_result = vecs[i].alu;
      exmem_rd_addr = vecs[i].rd; exmem_rd_wrt_en = vecs[i].wen; flush = vecs[i].fl;
      #1;
      checkOutput($sformatf("vec%0d_stall", i), {31'b0, mem_stall}, 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_req", i), {31'b0, dcache_req}, 32'd0);
      checkOutput($sformatf("vec%0d_wen", i), {31'b0, MemWb_RdWrtEn_0}, {31'b0, vecs[i].expWen});
      checkOutput($sformatf("vec%0d_mis", i), {31'b0, misalign_exc}, {31'b0, vecs[i].expMis});
      if (vecs[i].chkData) begin
        checkOutput($sformatf("vec%0d_rd", i), {27'b0, MemWb_RdAddr_0}, {27'b0, vecs[i].rd});
        checkOutput($sformatf("vec%0d_data", i), MemWb_Data_0, vecs[i].expData);
      end
    end
    clearInputs();
    @(posedge clk); #1;
    checkOutput("mis_one_cycle", {31'b0, misalign_exc}, 32'd0);

    // Ack while IDLE must be ignored
    dcache_ack = 1; dcache_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    checkOutput("idle_ack_req", {31'b0, dcache_req}, 32'd0);
    checkOutput("idle_ack_datard", Dcache_DataRd_0, 32'd0);
    clearInputs();

    // LB and LBU at byte offset 3, four stall cycles
    doMemOp(1, 0, 3'b000, 2'b00, 32'h1003, 0, 5'd11, 4, 32'h80FF_FF00, 0,
            32'h1000, 4'b1111, 0, stalls);
    checkOutput("lb_stalls", stalls, 4);
    checkOutput("lb_wen", {31'b0, MemWb_RdWrtEn_0}, 32'd1);
    checkOutput("lb_rd", {27'b0, MemWb_RdAddr_0}, 32'd11);
    checkOutput("lb_data", MemWb_Data_0, 32'hFFFF_FF80);
    doMemOp(1, 0, 3'b100, 2'b00, 32'h1003, 0, 5'd11, 4, 32'h80FF_FF00, 0,
            32'h1000, 4'b1111, 0, stalls);
    checkOutput("lbu_data", MemWb_Data_0, 32'h0000_0080);
    checkOutput("lbu_datard", Dcache_DataRd_0, 32'h0000_0080);

    // Half-word loads at offset 2
    doMemOp(1, 0, 3'b001, 2'b00, 32'h1002, 0, 5'd12, 2, 32'h8001_1234, 0,
            32'h1000, 4'b1111, 0, stalls);
    checkOutput("lh_data", MemWb_Data_0, 32'hFFFF_8001);
    doMemOp(1, 0, 3'b101, 2'b00, 32'h1002, 0, 5'd12, 2, 32'h8001_1234, 0,
            32'h1000, 4'b1111, 0, stalls);
    checkOutput("lhu_data", MemWb_Data_0, 32'h0000_8001);

    // Stores: SH upper half and SB at offset 1
    doMemOp(0, 1, 3'b010, 2'b01, 32'h2002, 32'hABCD_5678, 5'd0, 2, 0, 0,
            32'h2000, 4'b1100, 32'h5678_5678, stalls);
    checkOutput("sh_wen", {31'b0, MemWb_RdWrtEn_0}, 32'd0);
    doMemOp(0, 1, 3'b010, 2'b00, 32'h2001, 32'h1234_56A5, 5'd0, 1, 0, 0,
            32'h2000, 4'b0010, 32'hA5A5_A5A5, stalls);
    checkOutput("sb_wen", {31'b0, MemWb_RdWrtEn_0}, 32'd0);

    // Minimum-latency LW: ack in the first request cycle
    doMemOp(1, 0, 3'b010, 2'b00, 32'h3004, 0, 5'd9, 1, 32'h1234_5678, 0,
            32'h3004, 4'b1111, 0, stalls);
    checkOutput("lw_min_stalls", stalls, 1);
    checkOutput("lw_min_wen", {31'b0, MemWb_RdWrtEn_0}, 32'd1);
    checkOutput("lw_min_data", MemWb_Data_0, 32'h1234_5678);

    // Flush during ACCESS suppresses writeback but keeps the load data
    doMemOp(1, 0, 3'b010, 2'b00, 32'h3008, 0, 5'd7, 3, 32'hDEAD_BEEF, 1,
            32'h3008, 4'b1111, 0, stalls);
    checkOutput("flush_wen", {31'b0, MemWb_RdWrtEn_0}, 32'd0);
    checkOutput("flush_datard", Dcache_DataRd_0, 32'hDEAD_BEEF);

    // Reset asserted mid-ACCESS
    applyStimulus(1, 0, 3'b010, 2'b00, 32'h4000, 0, 5'd10);
    @(posedge clk); #1;
    checkOutput("rstmid_req_before", {31'b0, dcache_req}, 32'd1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    checkOutput("rstmid_req", {31'b0, dcache_req}, 32'd0);
    checkOutput("rstmid_stall", {31'b0, mem_stall}, 32'd0);
    checkOutput("rstmid_addr", dcache_addr, 32'd0);
    checkOutput("rstmid_datard", Dcache_DataRd_0, 32'd0);
    checkOutput("rstmid_rdaddr", {27'b0, MemWb_RdAddr_0}, 32'd0);
    clearInputs();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    doMemOp(1, 0, 3'b010, 2'b00, 32'h4000, 0, 5'd10, 2, 32'h0BAD_F00D, 0,
            32'h4000, 4'b1111, 0, stalls);
    checkOutput("post_rst_wen", {31'b0, MemWb_RdWrtEn_0}, 32'd1);
    checkOutput("post_rst_rd", {27'b0, MemWb_RdAddr_0}, 32'd10);
    checkOutput("post_rst_data", MemWb_Data_0, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory stage of the dual-issue pipe, slot 0 (the only slot with a load/store unit). Takes the EX/MEM register contents for slot 0 and issues word-aligned D-cache requests with byte enables. It holds the pipe with `mem_stall` while a request is outstanding, sign- or zero-extends load data, and drives the MEM/WB register. That register feeds writeback and the EX-stage forwarding/load-use logic through `MemWb_RdWrtEn_0`, `MemWb_RdAddr_0` and `Dcache_DataRd_0`.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- RF_ADDR_WIDTH, 5, register file address width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  single clock.
  - rst_n  in  1  asynchronous, active-low reset.
- EX/MEM inputs:
  - exmem_valid  in  1  slot-0 instruction present in EX/MEM.
  - exmem_ld_en  in  1  instruction is a load.
  - exmem_st_en  in  1  instruction is a store; never high together with `exmem_ld_en`.
  - exmem_ld_type  in  3  RISC-V funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - exmem_st_type  in  2  00 SB, 01 SH, 10 SW.
  - exmem_addr  in  DATA_WIDTH  effective byte address.
  - exmem_st_data  in  DATA_WIDTH  store data (rs2).
  - exmem_alu_result  in  DATA_WIDTH  result for non-memory instructions.
  - exmem_rd_addr  in  RF_ADDR_WIDTH  destination register.
  - exmem_rd_wrt_en  in  1  destination write enable.
  - flush  in  1  kill the slot-0 instruction (branch/exception redirect).
- D-cache interface:
  - dcache_req  out  1  request valid; held until `dcache_ack`.
  - dcache_we  out  1  1 = store.
  - dcache_addr  out  DATA_WIDTH  word address, bits [1:0] = 0.
  - dcache_wdata  out  DATA_WIDTH  replicated store data.
  - dcache_be  out  4  byte enables.
  - dcache_ack  in  1  one-cycle completion; `dcache_rdata` is valid in the same cycle.
  - dcache_rdata  in  DATA_WIDTH  read word.
- Pipe control and MEM/WB outputs:
  - mem_stall  out  1  hold EX/MEM and all upstream stages.
  - MemWb_RdWrtEn_0  out  1  registered writeback enable.
  - MemWb_RdAddr_0  out  RF_ADDR_WIDTH  registered destination.
  - MemWb_Data_0  out  DATA_WIDTH  registered writeback data: load result or ALU result.
  - Dcache_DataRd_0  out  DATA_WIDTH  registered formatted load data.
  - misalign_exc  out  1  registered one-cycle misaligned-access flag.

## Operation
- FSM has two states:
  - IDLE → ACCESS: when a memory op is accepted.
  - ACCESS → IDLE: on `dcache_ack`.
- Memory op is accepted in IDLE when all of the following hold:
  - `exmem_valid`;
  - `exmem_ld_en` or `exmem_st_en`;
  - `!flush`;
  - the access is aligned.
- On acceptance, registers are loaded:
  - `dcache_addr = {addr[31:2],2'b00}`;
  - `dcache_we = st_en`;
  - `dcache_be`;
  - `dcache_wdata`;
  - captured `byte_off = addr[1:0]`, load type, `rd_addr`, and `rd_wrt_en`.
- `dcache_req = 1` for the whole of ACCESS; address, data and enables are stable until ack.
- Alignment rules:
  - LH/LHU/SH require `addr[0] = 0`.
  - LW/SW require `addr[1:0] = 0`.
  - Bytes are always aligned.
- Undefined `ld_type` (011, 110, 111) is treated as LW; `st_type` 11 is treated as SW.
- Store formatting:
  - SB: `wdata = {4{st_data[7:0]}}`, `be = 4'b0001 << off`.
  - SH: `wdata = {2{st_data[15:0]}}`, `be = off[1] ? 1100 : 0011`.
  - SW: `wdata = st_data`, `be = 1111`.
  - Loads: `be = 1111`.
- Load formatting: `dcache_rdata >> (8*byte_off)`, then sign-extend (LB, LH) or zero-extend (LBU, LHU) from bit 7 or bit 15; LW passes through.
- `mem_stall = (IDLE && an op would be accepted) || (ACCESS && !dcache_ack)`. `mem_stall` is forced to 0 while `rst_n` is low.
- MEM/WB capture happens on every edge where `mem_stall = 0`:
  - Non-memory op: `RdWrtEn = valid && rd_wrt_en && !flush && rd != 0`; `Data = alu_result`.
  - Load completing (ack): `RdWrtEn = captured wrt_en && rd != 0 && !killed`; `Data = Dcache_DataRd_0 =` formatted data.
  - Store completing: `RdWrtEn = 0`.
  - Misaligned op in IDLE: no request, no stall; `RdWrtEn = 0`; `misalign_exc = 1` for one cycle unless `flush`.
  - While `mem_stall = 1`: `MemWb_RdWrtEn_0` is written 0 (bubble); `misalign_exc` is written 0.
- `Dcache_DataRd_0` updates only when a load completes; otherwise it holds its value.
- Flush handling:
  - `flush` in IDLE kills the incoming op, with no request.
  - `flush` in ACCESS sets `killed`. The request still runs to ack, so a store is still performed, but a load's writeback is suppressed. `killed` clears on return to IDLE.

## Timing
- Reset values: state IDLE; `dcache_req`, `dcache_we`, `dcache_addr`, `dcache_be`, `dcache_wdata` all 0; all MemWb outputs 0; `Dcache_DataRd_0` 0; `misalign_exc` 0; `killed` 0.
- Reset asserted mid-ACCESS: the FSM returns to IDLE immediately and `dcache_req` drops to 0. The D-cache must discard the request.
- Non-memory op: 1 cycle to MEM/WB, with no stall.
- Memory op:
  - Cycle T: accepted; `mem_stall = 1`.
  - T+1: `dcache_req = 1`.
  - Ack at T+k (k ≥ 1): stall drops in that cycle and MEM/WB is valid at T+k+1.
  - Minimum latency is 2 cycles.
- Back-to-back memory ops: the ack cycle returns the FSM to IDLE. The next op is accepted at the following edge, with one idle cycle between requests.
- `dcache_ack` while in IDLE is ignored.

## Test plan
- ADD writing x5 with `alu_result=0x1234`, no memory op → next cycle `MemWb_RdWrtEn_0=1`, `RdAddr=5`, `Data=0x1234`, `mem_stall` never 1.
- LB, `addr=0x1003`, `rdata=0x80FF_FF00`, ack 3 cycles after req → `be=1111`, `dcache_addr=0x1000`, stall for 4 cycles, `Data=0xFFFF_FF80`; the same access with LBU → `0x0000_0080`.
- SH, `addr=0x2002`, `st_data=0xABCD_5678` → `wdata=0x5678_5678`, `be=1100`, `we=1`, `RdWrtEn=0` after ack.
- LW at `0x3001` → no `dcache_req`, no stall, `misalign_exc=1` for exactly one cycle, `RdWrtEn=0`.
- LW to x7 with `flush` asserted during ACCESS, then ack with `0xDEAD_BEEF` → `RdWrtEn=0`; `Dcache_DataRd_0` still `0xDEAD_BEEF`.
- `rst_n` pulled low during ACCESS → `dcache_req=0`, state IDLE, all outputs 0; a new LW after release completes normally.
